uart_program_loader: RTL
========================

// Module: uart_program_loader
// PURPOSE
//  Sits between the UART receiver (byte stream, one rx_valid pulse per byte) and the core.
//  - Boot: assembles bytes into 32-bit words and writes the program into instruction memory.
//  - Start: releases the CPU once the program is loaded.
//  - Run: forwards every later byte to the core as program input data.
// PARAMETERS
//  ADDR_W     14  imem word-address width; max program = 2**ADDR_W words
//  MSB_FIRST   1  1: first byte of a word is bits[31:24]; 0: first byte is bits[7:0]
// PORTS
//  clk           in   1       system clock (one clock domain)
//  rstn          in   1       reset, asynchronous assert, active-low
//  rx_valid      in   1       one-cycle pulse: rx_data holds a new byte
//  rx_data       in   8       received byte
//  imem_we       out  1       instruction-memory write strobe
//  imem_addr     out  ADDR_W  word address of the write
//  imem_wdata    out  32      word being written
//  cpu_start     out  1       one-cycle pulse: program loaded
//  cpu_run       out  1       level: CPU may execute; held until reset
//  load_err      out  1       sticky: load aborted, CPU never started
//  words_loaded  out  ADDR_W+1  count of imem writes so far
//  rx_fwd_valid  out  1       run-phase byte pulse to the core
//  rx_fwd_data   out  8       run-phase byte
// BEHAVIOUR
//  Reset values
//  - All outputs are 0. State = S_HDR. Byte counter, shift register and word counter are cleared.
//  - Asserting rstn low mid-load discards any partial word. The next 4 bytes are a new header.
//  Byte assembly
//  - A 2-bit byte counter increments on each accepted rx_valid pulse.
//  - A word completes on the 4th byte. The counter then wraps to 0.
//  - Bytes are shifted into the word in the order given by MSB_FIRST.
//  S_HDR
//  - The completed word is N, the body length in words.
//  - N == 0: go to S_RUN (or to S_CSUM when the macro is defined).
//  - N > 2**ADDR_W: go to S_ERR.
//  - Otherwise: go to S_BODY.
//  S_BODY
//  - Each completed word is registered and produces imem_we = 1 for exactly one cycle.
//  - Timing: the write occurs in the cycle after the 4th byte's rx_valid.
//  - imem_addr = words_loaded, and words_loaded increments in that same cycle.
//  - After word N is written: go to S_RUN (or S_CSUM when the macro is defined).
//  Entering S_RUN
//  - cpu_start pulses one cycle after the last imem_we, or one cycle after the header completes when N == 0.
//  - cpu_run rises in the same cycle as cpu_start and stays at 1.
//  S_RUN
//  - Each rx_valid produces rx_fwd_valid = 1 one cycle later, with rx_fwd_data = that byte.
//  - imem_we is never asserted.
//  S_ERR
//  - load_err = 1. All bytes are dropped. Only reset exits this state.
//  Simultaneous events
//  - At most one byte arrives per cycle, so accepting a byte and writing the previous word cannot collide.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined
//  - Body words are summed mod 2**32 as they are written.
//  - In S_CSUM the loader accepts one more word.
//  - Trailer equal to the sum: cpu_start pulses in the cycle after the trailer completes, then S_RUN.
//  - Trailer not equal to the sum: S_ERR.
//  LOADER_CHECKSUM_EN undefined
//  - No S_CSUM state, no sum register. Sequencing is as described above.
// STRUCTURE
//  loader_pkg
//  - typedef enum {S_HDR, S_BODY, S_CSUM, S_RUN, S_ERR} loader_state_t
//  - localparam WORD_W = 32, BYTES_PER_WORD = 4
//  Sub-module uart_word_asm
//  - Byte counter plus 32-bit shift register.
//  - Outputs word_valid (one cycle after the 4th byte) and word.
//  - Has a clear input used on reset.
//  The top-level FSM, counters and forwarding live in uart_program_loader.
// TESTING
//  Byte gaps: bytes are >= 10 cycles apart unless a test states otherwise.
//  1 Load: header 00000002, words 12345678, DEADBEEF
//    -> writes addr0 = 12345678 and addr1 = DEADBEEF
//    -> cpu_start pulses 1 cycle after the 2nd write; cpu_run = 1; words_loaded = 2
//  2 Empty program: header 00000000
//    -> no imem_we; cpu_start 1 cycle after the 4th byte
//  3 Oversize: ADDR_W = 14, header 00004001
//    -> load_err = 1; no imem_we; cpu_run = 0
//    -> a further 8 bytes produce no output activity
//  4 Forwarding: after test 1, send byte A5
//    -> rx_fwd_valid = 1 with rx_fwd_data = A5 exactly one cycle later; imem_we stays 0
//  5 Reset mid-load: header 00000001, then 2 body bytes, then pulse rstn low
//    -> all outputs 0
//    -> the next 4 bytes (00000000) act as a header: cpu_start pulses
//  6 Checksum (LOADER_CHECKSUM_EN): body as in test 1
//    -> trailer F0E21567: run
//    -> trailer F0E21568: load_err = 1, cpu_start never pulses
//  Back-to-back: rx_valid on consecutive cycles during the body still gives one write per 4 bytes.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the UART program loader.
//   loader_state_t : loader sequencing states
//   WORD_W         : instruction word width in bits
//   BYTES_PER_WORD : UART bytes per instruction word
//   is_loading()   : true while bytes still feed the word assembler
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_HDR,
        S_BODY,
        S_CSUM,
        S_RUN,
        S_ERR
    } loader_state_t;

    function automatic logic is_loading(input loader_state_t s);
        return (s == S_HDR) || (s == S_BODY) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/uart_word_asm.sv
// ---------------------------------------------------------------------------
// uart_word_asm
// Packs a stream of UART bytes into 32-bit words.
// Parameters:
//   MSB_FIRST     1: first byte lands in bits[31:24]; 0: first byte in bits[7:0]
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   i_clear       in   synchronous clear of counter, shift register and valid
//   i_byte_valid  in   accept i_byte_data this cycle
//   i_byte_data   in   8-bit byte
//   o_word_valid  out  one-cycle pulse, the cycle after the 4th byte
//   o_word        out  assembled word (stable while o_word_valid is high)
// ---------------------------------------------------------------------------
module uart_word_asm
    import loader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clear,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_word_valid;
    logic [WORD_W-1:0] w_shift_next;

    // MSB-first shifts left so the first byte ends up on top; LSB-first
    // shifts right so the first byte ends up at the bottom.
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[WORD_W-9:0], i_byte_data};
        end else begin
            w_shift_next = {i_byte_data, r_shift[WORD_W-1:8]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 2'd1;   // wraps to 0 after the last byte
                if (r_cnt == CNT_LAST) begin
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

endmodule

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
// Boot loader between the UART receiver and the core. The first word is the
// program length N, the next N words are written to instruction memory, then
// the CPU is released and every later byte is forwarded to the core.
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : one trailer word after the body must equal the mod-2**32 sum
//               of the body words, otherwise the load aborts.
//   undefined : no trailer, the CPU starts right after the body.
// Parameters:
//   ADDR_W        imem word-address width (max program 2**ADDR_W words)
//   MSB_FIRST     byte order inside a word
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   rx_valid      in   one-cycle pulse per received byte
//   rx_data       in   received byte
//   imem_we       out  instruction-memory write strobe
//   imem_addr     out  word address of the write
//   imem_wdata    out  word being written
//   cpu_start     out  one-cycle pulse when the program is loaded
//   cpu_run       out  CPU may execute; held until reset
//   load_err      out  sticky load-abort flag
//   words_loaded  out  number of imem writes so far
//   rx_fwd_valid  out  run-phase byte pulse to the core
//   rx_fwd_data   out  run-phase byte
// ---------------------------------------------------------------------------
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_start,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic              rx_fwd_valid,
    output logic [7:0]        rx_fwd_data
);

    localparam logic [WORD_W:0] MAX_WORDS = (WORD_W+1)'(1) << ADDR_W;

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W:0]   r_n;
    logic              r_start_pend;
    logic              r_fwd_valid;
    logic [7:0]        r_fwd_data;

    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;
    logic              w_asm_valid;
    logic              w_asm_clear;
    logic              w_fwd_accept;
    logic              w_we;
    logic              w_start;
    logic              w_hdr_too_big;
    logic              w_last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;
`endif

    // A byte belongs to the loader only while the FSM stays in a loading
    // state; a byte arriving in the cycle the load finishes is already a
    // run-phase byte and is forwarded instead of being swallowed.
    assign w_asm_valid  = rx_valid && is_loading(w_next);
    assign w_fwd_accept = rx_valid && (w_next == S_RUN);
    assign w_asm_clear  = !is_loading(r_state);

    uart_word_asm #(
        .MSB_FIRST (MSB_FIRST)
    ) u_word_asm (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_asm_clear),
        .i_byte_valid (w_asm_valid),
        .i_byte_data  (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign w_hdr_too_big = {1'b0, w_word} > MAX_WORDS;
    // r_words < r_n <= 2**ADDR_W while in S_BODY, so the +1 cannot overflow.
    assign w_last_word   = (r_words + (ADDR_W+1)'(1)) == r_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_start = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_word_valid) begin
                    if (w_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = S_CSUM;
`else
                        w_next  = S_RUN;
                        w_start = 1'b1;
`endif
                    end else if (w_hdr_too_big) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (w_word_valid) begin
                    w_we = 1'b1;
                    if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = S_CSUM;
`else
                        w_next = S_RUN;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_word_valid) begin
                    if (w_word == r_sum) begin
                        w_next  = S_RUN;
                        w_start = 1'b1;
                    end else begin
                        w_next = S_ERR;
                    end
                end
            end
`endif
            S_RUN: begin
                // Start after a non-empty body lags the last write by a cycle.
                w_start = r_start_pend;
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_words      <= '0;
            r_n          <= '0;
            r_start_pend <= 1'b0;
        end else begin
            r_start_pend <= (r_state == S_BODY) && w_we && (w_next == S_RUN);
            if ((r_state == S_HDR) && w_word_valid) begin
                r_n <= w_word[ADDR_W:0];
            end
            if (w_we) begin
                r_words <= r_words + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
        end else if (w_we) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_fwd_accept;
            if (w_fwd_accept) begin
                r_fwd_data <= rx_data;
            end
        end
    end

    assign imem_we      = w_we;
    assign imem_addr    = r_words[ADDR_W-1:0];
    assign imem_wdata   = w_word;
    assign cpu_start    = w_start;
    assign cpu_run      = (r_state == S_RUN) || w_start;
    assign load_err     = (r_state == S_ERR);
    assign words_loaded = r_words;
    assign rx_fwd_valid = r_fwd_valid;
    assign rx_fwd_data  = r_fwd_data;

endmodule
